// File: rtl/neuron_mac_lanes.sv
// Multi-lane neuron: pipelined multiply / adder tree / saturating accumulate, bias, ReLU, valid/ready on both sides.
// Optional build macro NEURON_LEAKY_RELU_EN selects a leaky negative slope instead of zeroing negative results.
module neuron_mac_lanes #(
  parameter int LAYER_NO         = 1,
  parameter int NEURON_NO        = 0,
  parameter int NUM_WEIGHT       = 784,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 1,
  parameter int LANES            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        weight_valid,
  input  logic [DATA_WIDTH-1:0]       weight_value,
  input  logic                        bias_valid,
  input  logic [DATA_WIDTH-1:0]       bias_value,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int SHIFT = DATA_WIDTH - WEIGHT_INT_WIDTH;
  localparam int BEATS = (NUM_WEIGHT + LANES - 1) / LANES;
  localparam int LG    = $clog2(LANES);
  localparam int LW    = (LANES > 1) ? LG : 1;
  localparam int RW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int SW    = PW + LG;
  localparam int EW    = PW + LG + 2;

  localparam logic signed [EW-1:0] ACC_MAX = EW'({1'b0, {(PW-1){1'b1}}});
  localparam logic signed [EW-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [PW-1:0] OUT_MAX = PW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [2:0] {S_ACCUM, S_DRAIN, S_BIAS, S_ACT, S_OUT} state_t;

  state_t                         state;
  logic [RW-1:0]                  beat_cnt;
  logic [IW-1:0]                  w_idx;
  logic [LW-1:0]                  w_lane;
  logic [RW-1:0]                  w_row;
  logic                           v0, v1, v2;
  logic signed [PW-1:0]           acc;
  logic signed [DATA_WIDTH-1:0]   bias_reg;
  logic signed [DATA_WIDTH-1:0]   wmem [LANES][BEATS];
  logic signed [DATA_WIDTH-1:0]   s0_x [LANES];
  logic signed [DATA_WIDTH-1:0]   s0_w [LANES];
  logic signed [PW-1:0]           s1_p [LANES];
  logic signed [SW-1:0]           tree_sum;
  logic signed [SW-1:0]           s2_sum;
  logic [LANES-1:0]               lane_en;
  logic signed [DATA_WIDTH-1:0]   act;
  logic signed [PW-1:0]           shifted;
  logic                           hs, last_beat, cfg_match, w_wr, b_wr;

  function automatic logic signed [PW-1:0] sat(input logic signed [EW-1:0] x);
    if (x > ACC_MAX)      return PW'(ACC_MAX);
    else if (x < ACC_MIN) return PW'(ACC_MIN);
    else                  return PW'(x);
  endfunction

  assign hs        = in_valid & in_ready;
  assign last_beat = (beat_cnt == RW'(BEATS - 1));
  assign cfg_match = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign w_wr      = weight_valid & cfg_match;
  assign b_wr      = bias_valid & cfg_match;
  assign w_lane    = LW'(32'(w_idx) % 32'(LANES));
  assign w_row     = RW'(32'(w_idx) / 32'(LANES));

  // Lanes past the end of the weight vector in the final beat are forced to zero operands.
  always_comb begin
    lane_en = '0;
    for (int unsigned k = 0; k < LANES; k++)
      lane_en[k] = (32'(beat_cnt) * 32'(LANES) + k) < 32'(NUM_WEIGHT);
  end

  always_comb begin
    tree_sum = '0;
    for (int unsigned k = 0; k < LANES; k++)
      tree_sum = tree_sum + SW'(s1_p[k]);
  end

  always_comb begin
    act     = '0;
    shifted = '0;
    if (acc[PW-1]) begin
`ifdef NEURON_LEAKY_RELU_EN
      shifted = acc >>> (SHIFT + 3);
      act     = (shifted < OUT_MIN) ? DATA_WIDTH'(OUT_MIN) : DATA_WIDTH'(shifted);
`else
      act     = '0;
`endif
    end else begin
      shifted = acc >>> SHIFT;
      act     = (shifted > OUT_MAX) ? DATA_WIDTH'(OUT_MAX) : DATA_WIDTH'(shifted);
    end
  end

  // Datapath registers and weight memory carry no reset; validity is tracked by v0..v2.
  always_ff @(posedge clk) begin
    if (w_wr)
      wmem[w_lane][w_row] <= weight_value;
    if (hs) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        s0_x[k] <= lane_en[k] ? in_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        s0_w[k] <= lane_en[k] ? wmem[k][beat_cnt] : '0;
      end
    end
    for (int unsigned k = 0; k < LANES; k++)
      s1_p[k] <= PW'(s0_x[k]) * PW'(s0_w[k]);
    s2_sum <= tree_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ACCUM;
      beat_cnt  <= '0;
      w_idx     <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      acc       <= '0;
      bias_reg  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      v0 <= hs;
      v1 <= v0;
      v2 <= v1;
      if (v2)
        acc <= sat(EW'(acc) + EW'(s2_sum));
      if (w_wr)
        w_idx <= (w_idx == IW'(NUM_WEIGHT - 1)) ? '0 : w_idx + 1'b1;
      if (b_wr)
        bias_reg <= bias_value;

      case (state)
        S_ACCUM: begin
          in_ready <= 1'b1;
          if (hs) begin
            if (last_beat) begin
              beat_cnt <= '0;
              in_ready <= 1'b0;
              state    <= S_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!v0 && !v1 && !v2)
            state <= S_BIAS;
        end
        S_BIAS: begin
          acc   <= sat(EW'(acc) + (EW'(bias_reg) <<< SHIFT));
          state <= S_ACT;
        end
        S_ACT: begin
          out_data  <= act;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b1;
            state     <= S_ACCUM;
          end
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

endmodule
